// File: rtl/a2d_rr_sched_if.sv
// SPI master handshake between the A2D round-robin scheduler and the SPI master.
// The scheduler is the master side: it issues wrt/cmd and consumes done/resp.
interface a2d_rr_sched_if;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] resp;

   modport master (output wrt, output cmd, input done, input resp);
   modport slave  (input wrt, input cmd, output done, output resp);
endinterface

// File: rtl/a2d_rr_sched.sv
// Round-robin ADC128S conversion scheduler: one channel per nxt (two SPI transactions each).
// Optional macro A2D_SWEEP_EN: one nxt sweeps all four channels back to back.
module a2d_rr_sched #(
   parameter logic [2:0]  CH_LFT   = 3'd0,
   parameter logic [2:0]  CH_RGHT  = 3'd4,
   parameter logic [2:0]  CH_STEER = 3'd5,
   parameter logic [2:0]  CH_BATT  = 3'd6,
   parameter int unsigned GAP_CYC  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  nxt,
   a2d_rr_sched_if.master        spi,
   output logic [11:0]           lft_ld,
   output logic [11:0]           rght_ld,
   output logic [11:0]           steer_pot,
   output logic [11:0]           batt,
   output logic                  busy,
   output logic [1:0]            rr_ptr
);

   typedef enum logic [2:0] {IDLE, XMIT1, GAP, XMIT2, STORE} state_t;

   localparam logic [2:0] GAP_LD = 3'(GAP_CYC - 1);

   state_t      state_q;
   logic        wrt_q;
   logic [15:0] cmd_q;
   logic        busy_q;
   logic [1:0]  ptr_q;
   logic [1:0]  ptr_d;
   logic [2:0]  gap_q;
   logic [11:0] data_q;
   logic [11:0] lft_q;
   logic [11:0] rght_q;
   logic [11:0] steer_q;
   logic [11:0] batt_q;

   function automatic logic [15:0] cmd_for(input logic [1:0] ptr);
      logic [2:0] ch;
      case (ptr)
         2'd0:    ch = CH_LFT;
         2'd1:    ch = CH_RGHT;
         2'd2:    ch = CH_STEER;
         default: ch = CH_BATT;
      endcase
      return {2'b00, ch, 11'h000};
   endfunction

   assign ptr_d = ptr_q + 2'd1;

   // NOTE: all state below uses non-blocking assignments so every register samples
   // pre-edge values; wrt_q defaults low each cycle, which makes it a one-clock pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wrt_q   <= 1'b0;
         cmd_q   <= 16'h0000;
         busy_q  <= 1'b0;
         ptr_q   <= 2'd0;
         gap_q   <= 3'd0;
         data_q  <= 12'h000;
         lft_q   <= 12'h000;
         rght_q  <= 12'h000;
         steer_q <= 12'h000;
         batt_q  <= 12'h000;
      end else begin
         wrt_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (nxt) begin
                  wrt_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= XMIT1;
`ifdef A2D_SWEEP_EN
                  ptr_q   <= 2'd0;
                  cmd_q   <= cmd_for(2'd0);
`else
                  cmd_q   <= cmd_for(ptr_q);
`endif
               end
            end
            // First response carries the previous conversion and is dropped.
            XMIT1: begin
               if (spi.done) begin
                  gap_q   <= GAP_LD;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (gap_q == 3'd0) begin
                  wrt_q   <= 1'b1;
                  state_q <= XMIT2;
               end else begin
                  gap_q <= gap_q - 3'd1;
               end
            end
            XMIT2: begin
               if (spi.done) begin
                  data_q  <= spi.resp[11:0];
                  state_q <= STORE;
               end
            end
            STORE: begin
               case (ptr_q)
                  2'd0:    lft_q   <= data_q;
                  2'd1:    rght_q  <= data_q;
                  2'd2:    steer_q <= data_q;
                  default: batt_q  <= data_q;
               endcase
               ptr_q <= ptr_d;
`ifdef A2D_SWEEP_EN
               if (ptr_q == 2'd3) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  wrt_q   <= 1'b1;
                  cmd_q   <= cmd_for(ptr_d);
                  state_q <= XMIT1;
               end
`else
               busy_q  <= 1'b0;
               state_q <= IDLE;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign spi.wrt   = wrt_q;
   assign spi.cmd   = cmd_q;
   assign lft_ld    = lft_q;
   assign rght_ld   = rght_q;
   assign steer_pot = steer_q;
   assign batt      = batt_q;
   assign busy      = busy_q;
   assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Scoreboard bench for a2d_rr_sched: stimulus queues expected SPI commands and stores,
// a negedge monitor pops and compares them; an ADC model answers each SPI transaction.
module tb_a2d_rr_sched;
   localparam int GAP_CYC  = 2;
   localparam int RESP_LAT = 8;
   localparam int BUDGET   = 400;

   typedef struct packed {
      logic [15:0] cmd;
      logic        second;
   } cmd_exp_t;

   typedef struct packed {
      logic [3:0][11:0] regs;
      logic [1:0]       ptr;
   } res_exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        nxt;
   logic [11:0] lft_ld, rght_ld, steer_pot, batt;
   logic        busy;
   logic [1:0]  rr_ptr;
   logic        adc_done, spur_done;
   logic [15:0] adc_resp;

   a2d_rr_sched_if spi ();

   assign spi.done = adc_done | spur_done;
   assign spi.resp = adc_resp;

   a2d_rr_sched #(.GAP_CYC(GAP_CYC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .nxt       (nxt),
      .spi       (spi),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .steer_pot (steer_pot),
      .batt      (batt),
      .busy      (busy),
      .rr_ptr    (rr_ptr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cmd_exp_t         exp_cmd[$];
   res_exp_t         exp_res[$];
   int               n_checks = 0;
   int               n_errors = 0;
   logic [11:0]      adc_val [4];
   logic [3:0][11:0] mdl;
   logic [15:0]      cmd_tab [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [11:0] val_of(input logic [2:0] ch);
      case (ch)
         3'd0:    return adc_val[0];
         3'd4:    return adc_val[1];
         3'd5:    return adc_val[2];
         3'd6:    return adc_val[3];
         default: return 12'hFFF;
      endcase
   endfunction

   // ADC128S model: each transaction returns the channel addressed by the previous one.
   logic [2:0] prev_ch = 3'd0;
   logic [2:0] cur_ch;
   initial begin
      adc_done = 1'b0;
      adc_resp = 16'h0000;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && spi.wrt === 1'b1) begin
            cur_ch = spi.cmd[13:11];
            repeat (RESP_LAT) @(posedge clk);
            #1;
            adc_resp = {4'hA, val_of(prev_ch)};
            prev_ch  = cur_ch;
            adc_done = 1'b1;
            @(posedge clk);
            #1;
            adc_done = 1'b0;
            adc_resp = 16'hDEAD;
         end
      end
   end

   // Monitor: compares every wrt pulse and every end of conversion against the queues.
   logic             mon_prev_busy = 1'b0;
   logic [15:0]      mon_last_cmd = 16'h0000;
   int               mon_done_cyc = 0;
   logic [3:0][11:0] exp_regs = '0;
   cmd_exp_t         ce;
   res_exp_t         re;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            mon_prev_busy = 1'b0;
            exp_regs      = '0;
         end else begin
            if (adc_done) begin
               check("cmd_hold", spi.cmd, mon_last_cmd);
               mon_done_cyc = cyc;
            end
            if (spi.wrt) begin
               if (exp_cmd.size() == 0) begin
                  check("wrt_unexpected", spi.wrt, 0);
               end else begin
                  ce = exp_cmd.pop_front();
                  check("cmd", spi.cmd, ce.cmd);
                  if (ce.second) check("gap_len", cyc - mon_done_cyc, GAP_CYC + 1);
                  mon_last_cmd = spi.cmd;
               end
            end
            if (mon_prev_busy && !busy) begin
               if (exp_res.size() == 0) begin
                  check("store_unexpected", busy, 1);
               end else begin
                  re = exp_res.pop_front();
                  exp_regs = re.regs;
                  check("rr_ptr", rr_ptr, re.ptr);
                  check("store_latency", cyc - mon_done_cyc, 2);
               end
            end
            check("regs", {batt, steer_pot, rght_ld, lft_ld}, exp_regs);
            mon_prev_busy = busy;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_nxt();
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
   endtask

   // Returns one cycle after the cycle in which the ADC model raised done.
   task automatic wait_adc_done();
      int n = 0;
      @(negedge clk);
      while (adc_done !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) check("done_timeout", n, 0);
      tick();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < BUDGET) begin
         tick();
         n++;
      end
      if (n >= BUDGET) check("busy_timeout", n, 0);
   endtask

   // mode 0 plain, 1 spurious done in GAP, 2 nxt while busy (incl. STORE cycle), 3 reset in GAP
   task automatic convert(input int idx, input int mode);
      cmd_exp_t c;
      res_exp_t r;
      c.cmd    = cmd_tab[idx];
      c.second = 1'b0;
      exp_cmd.push_back(c);
      if (mode != 3) begin
         c.second = 1'b1;
         exp_cmd.push_back(c);
         mdl[idx] = adc_val[idx];
         r.regs   = mdl;
         r.ptr    = 2'(idx + 1);
         exp_res.push_back(r);
      end
      pulse_nxt();
      case (mode)
         1: begin
            wait_adc_done();
            spur_done = 1'b1;
            tick();
            spur_done = 1'b0;
         end
         2: begin
            tick();
            pulse_nxt();
            wait_adc_done();
            pulse_nxt();
            wait_adc_done();
            pulse_nxt();
         end
         3: begin
            wait_adc_done();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            mdl   = '0;
         end
         default: ;
      endcase
      wait_idle();
      repeat (20) tick();
      check("wrt_count", exp_cmd.size(), 0);
      check("store_count", exp_res.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_tab   = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
      adc_val   = '{12'h300, 12'h2F0, 12'h800, 12'hC00};
      mdl       = '0;
      rst_n     = 1'b0;
      nxt       = 1'b0;
      spur_done = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;

      repeat (1000) tick();
      check("idle_busy", busy, 0);
      check("idle_rr_ptr", rr_ptr, 0);
      check("idle_wrt", spi.wrt, 0);
      check("idle_cmd", spi.cmd, 16'h0000);
      check("idle_regs", {batt, steer_pot, rght_ld, lft_ld}, 48'h0);

      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      repeat (5) tick();
      check("idle_done_busy", busy, 0);
      check("idle_done_rr_ptr", rr_ptr, 0);

`ifdef A2D_SWEEP_EN
      begin
         cmd_exp_t c;
         res_exp_t r;
         for (int i = 0; i < 4; i++) begin
            c.cmd    = cmd_tab[i];
            c.second = 1'b0;
            exp_cmd.push_back(c);
            c.second = 1'b1;
            exp_cmd.push_back(c);
         end
         r.regs = {12'hC00, 12'h800, 12'h2F0, 12'h300};
         r.ptr  = 2'd0;
         exp_res.push_back(r);
         pulse_nxt();
         repeat (30) tick();
         check("sweep_busy_mid", busy, 1);
         pulse_nxt();
         wait_idle();
         repeat (20) tick();
         check("sweep_wrt_count", exp_cmd.size(), 0);
         check("sweep_store_count", exp_res.size(), 0);
         check("sweep_rr_ptr", rr_ptr, 0);
         check("sweep_regs", {batt, steer_pot, rght_ld, lft_ld},
               {12'hC00, 12'h800, 12'h2F0, 12'h300});
      end
`else
      convert(0, 0);
      convert(1, 0);
      convert(2, 1);
      convert(3, 0);
      check("round1_regs", {batt, steer_pot, rght_ld, lft_ld},
            {12'hC00, 12'h800, 12'h2F0, 12'h300});

      adc_val[3] = 12'h9A0;
      for (int i = 0; i < 4; i++) convert(i, 0);
      check("round2_regs", {batt, steer_pot, rght_ld, lft_ld},
            {12'h9A0, 12'h800, 12'h2F0, 12'h300});
      check("round2_rr_ptr", rr_ptr, 0);

      convert(0, 2);
      check("busy_ignore_rr_ptr", rr_ptr, 1);

      convert(1, 3);
      check("rst_busy", busy, 0);
      check("rst_wrt", spi.wrt, 0);
      check("rst_rr_ptr", rr_ptr, 0);
      check("rst_regs", {batt, steer_pot, rght_ld, lft_ld}, 48'h0);

      convert(0, 0);
      check("post_rst_lft", lft_ld, 12'h300);
      check("post_rst_rr_ptr", rr_ptr, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/a2d_rr_sched.md
Name: a2d_rr_sched

Overview:
- Round-robin conversion scheduler for the ADC128S A2D shared by the left load cell, right load cell, steering pot and battery monitor.
- On each trigger pulse (nxt, driven from inertial-sample valid), sequences one channel conversion through the existing SPI master using its wrt/done handshake.
- Unpacks the 12-bit result into one of four holding registers and advances the channel pointer.
- Sits between the SPI master and the balance, steer-enable and battery-check logic in Segway.

Parameters:
- CH_LFT, 3'd0, A2D channel for left load cell
- CH_RGHT, 3'd4, A2D channel for right load cell
- CH_STEER, 3'd5, A2D channel for steering pot
- CH_BATT, 3'd6, A2D channel for battery
- GAP_CYC, 2, idle clocks enforced between the two SPI transactions of a conversion (1..7)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset (synchronized global reset)
- nxt  input  1  single-cycle request to start the next conversion
- done  input  1  SPI master transaction-complete pulse
- resp  input  16  SPI master read data, valid when done=1
- wrt  output  1  single-cycle pulse to start an SPI transaction
- cmd  output  16  SPI command word, {2'b00, ch[2:0], 11'h000}
- lft_ld  output  12  latest left load cell reading
- rght_ld  output  12  latest right load cell reading
- steer_pot  output  12  latest steering pot reading
- batt  output  12  latest battery reading
- busy  output  1  high from nxt acceptance until result is stored
- rr_ptr  output  2  index of the next channel to convert: 0=lft, 1=rght, 2=steer, 3=batt

Behaviour:
- Reset values: all four result registers 12'h000, rr_ptr=0, wrt=0, busy=0, cmd=16'h0000; FSM in IDLE.
- FSM states: IDLE, XMIT1, GAP, XMIT2, STORE.
- IDLE:
  - nxt=1 -> wrt=1 for one cycle, cmd set from the channel selected by rr_ptr, busy=1, go to XMIT1.
  - nxt=0 -> stay in IDLE.
- XMIT1: wait for done. resp from this transaction is discarded (it carries the previous conversion). On done -> GAP, load the gap counter.
- GAP: count GAP_CYC clocks, then wrt=1 for one cycle with the same cmd -> XMIT2.
- XMIT2: on done, capture resp[11:0] -> STORE.
- STORE (one cycle):
  - Write the captured value into the register selected by rr_ptr.
  - rr_ptr <= rr_ptr+1; wraps 3 -> 0.
  - busy=0 -> IDLE.
- cmd is held stable from wrt through done of both transactions.
- Latency: result register updates exactly 1 clk after the second done.
- nxt arriving while busy=1 is ignored. Requests are not queued and rr_ptr does not advance.
- nxt and the final STORE in the same cycle: nxt is ignored (FSM is not in IDLE).
- done while in IDLE or GAP is ignored. No state change, no register write.
- resp[15:12] is ignored.
- Reset mid-conversion returns to reset values immediately:
  - Partially captured data is discarded.
  - Result registers clear to 0.
  - The next conversion after reset is lft.
- Result registers change only in STORE; between updates they hold their values.

Optional Feature:
- Macro: A2D_SWEEP_EN.
- Defined:
  - One nxt launches a sweep of all four channels in order lft, rght, steer, batt, starting from channel 0 regardless of rr_ptr.
  - After each STORE the FSM re-enters XMIT1 with the next channel directly, without returning to IDLE.
  - busy stays high until the batt STORE; rr_ptr reads 0 afterwards.
  - nxt during a sweep is ignored.
- Not defined: one channel per nxt, as described above.

Test Plan:
- Reset, no nxt for 1000 clks -> wrt never asserts; all results 0; rr_ptr=0; busy=0.
- ADC model with ld_cell_lft=12'h300, ld_cell_rght=12'h2F0, steerPot=12'h800, batt=12'hC00; 4 nxt pulses spaced 2000 clks -> lft_ld=12'h300, rght_ld=12'h2F0, steer_pot=12'h800, batt=12'hC00; cmd channels seen in order 0,4,5,6; exactly 2 wrt pulses per nxt.
- Continue with 4 more nxt after changing batt to 12'h9A0 -> only batt changes to 12'h9A0 on the 8th conversion; rr_ptr back to 0.
- Pulse nxt 3 times while busy=1 during the first conversion -> only one conversion occurs; rr_ptr advances by exactly 1.
- Assert rst_n=0 for 1 clk during GAP of the rght conversion -> busy=0, wrt=0, results 0; the following nxt produces cmd channel 0.
- With A2D_SWEEP_EN defined, a single nxt -> 8 wrt pulses; all four registers updated; busy high throughout then low; rr_ptr=0.
